// File: rtl/wb_tube_arb.sv
// rtl/wb_tube_arb.sv - two-master round-robin Wishbone arbiter in front of the Tube controller
// Optional forced-completion timeout enabled by defining TUBE_ARB_TIMEOUT_EN.
module wb_tube_arb #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [2:0]  m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [2:0]  m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [2:0]  s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   last, last_nx;
  logic   timeout_q, timeout_nx;
  logic   tmo_hit;

  logic        m0_req, m1_req;
  logic        own_stb, own_cyc, own_we;
  logic [2:0]  own_adr;
  logic [3:0]  own_sel;
  logic [31:0] own_dat;

  assign m0_req  = m0_stb_i & m0_cyc_i;
  assign m1_req  = m1_stb_i & m1_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_we  = owner ? m1_we_i  : m0_we_i;
  assign own_adr = owner ? m1_adr_i : m0_adr_i;
  assign own_sel = owner ? m1_sel_i : m0_sel_i;
  assign own_dat = owner ? m1_dat_i : m0_dat_i;

`ifdef TUBE_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] count;

  // count holds the number of BUSY cycles already spent, so the hit lands on the TIMEOUT-th one
  always_ff @(posedge clk) begin
    if (reset || state != BUSY || s_ack_i)
      count <= '0;
    else
      count <= count + 8'd1;
  end

  assign tmo_hit = (state == BUSY) && !s_ack_i && (count == TMO_LAST);
`else
  assign tmo_hit = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign timeout_o = timeout_q;

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    last_nx    = last;
    timeout_nx = timeout_q;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_sel_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_dat_o   = s_dat_i;
    m1_dat_o   = s_dat_i;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_nx = (m0_req && m1_req) ? ~last : m1_req;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // stb is qualified by cyc so an abandon drops both on the same cycle
        s_stb_o  = own_stb & own_cyc;
        s_cyc_o  = own_cyc;
        s_we_o   = own_we;
        s_adr_o  = own_adr;
        s_sel_o  = own_sel;
        s_dat_o  = own_dat;
        m0_ack_o = !owner & s_ack_i;
        m1_ack_o = owner & s_ack_i;
        if (s_ack_i) begin
          last_nx  = owner;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          if (owner) begin
            m1_ack_o = 1'b1;
            m1_dat_o = 32'hFFFF_FFFF;
          end else begin
            m0_ack_o = 1'b1;
            m0_dat_o = 32'hFFFF_FFFF;
          end
          timeout_nx = 1'b1;
          last_nx    = owner;
          state_nx   = DRAIN;
        end else if (!own_cyc) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (s_ack_i) begin
          last_nx  = owner;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/wb_tube_arb.md
Name: wb_tube_arb

Overview:
- Two-master Wishbone arbiter that shares the single Wishbone Tube controller (3-bit address, 8-bit Tube data in a 32-bit word) between master 0 (CPU data port) and master 1 (DMA / debug port).
- Round-robin grant, one transfer per grant.
- Forwarding is combinational once granted.
- An abandoned transfer still completes on the Tube side, so the arbiter drains its orphaned ack.

Parameters:
- TIMEOUT, 15: cycles in BUSY before a forced completion (used only with TUBE_ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_stb_i, m0_cyc_i, m0_we_i  in  1 each  master 0 strobe/cycle/write
- m0_adr_i  in  3  master 0 address
- m0_sel_i  in  4  master 0 byte selects
- m0_dat_i  in  32  master 0 write data
- m0_ack_o  out  1  master 0 ack
- m0_dat_o  out  32  master 0 read data
- m1_* (same 8 ports as m0_*)  master 1
- s_stb_o, s_cyc_o, s_we_o  out  1 each  to Tube controller
- s_adr_o  out  3
- s_sel_o  out  4
- s_dat_o  out  32
- s_ack_i  in  1
- s_dat_i  in  32
- timeout_o  out  1  sticky timeout flag (constant 0 without the macro)

Behaviour:
- Request: mX_req = mX_stb_i & mX_cyc_i.
- State register values: IDLE, BUSY, DRAIN. Owner register: 1 bit. Last-served register: last, reset to 1 so master 0 wins the first tie.
- Reset: state=IDLE, owner=0, last=1, timeout_o=0, count=0.
- IDLE:
  - Slave outputs all 0 (stb, cyc, we, adr, sel, dat).
  - m0_ack_o = m1_ack_o = 0.
  - If only one master requests, owner gets that master.
  - If both request, owner = ~last.
  - On any grant: go BUSY, count=0.
  - Grant costs one cycle (IDLE→BUSY); no slave strobe in the grant cycle.
- BUSY:
  - Slave stb/cyc/we/adr/sel/dat = the owner's inputs, combinationally.
  - owner ack_o = s_ack_i; non-owner ack_o = 0.
  - Both mX_dat_o = s_dat_i at all times.
  - s_ack_i=1 → last=owner, go IDLE. The slave's ack is a single-cycle registered pulse and is low again by the next grant.
  - Owner cyc_i drops with s_ack_i=0 (abandon) → go DRAIN; slave stb/cyc drop that same cycle.
  - s_ack_i and cyc drop in the same cycle → treated as ack, go IDLE.
- DRAIN:
  - Slave outputs 0; no ack forwarded to either master.
  - On s_ack_i=1: last=owner, go IDLE.
  - New requests wait; the Tube controller cannot accept a new cycle until its ack.
- Starvation bound: a master requesting continuously is granted within one other transfer.
- s_ack_i while IDLE is ignored and not forwarded.
- Reset mid-transfer returns to IDLE immediately. The Tube controller is on the same reset and clears too.

Optional Feature:
- Macro TUBE_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit count increments each BUSY cycle without s_ack_i.
  - When count == TIMEOUT, the owner gets ack_o=1 with mX_dat_o = 32'hFFFF_FFFF in that cycle.
  - Same cycle: timeout_o set (sticky until reset), last=owner, go DRAIN.
  - s_ack_i arriving in that same cycle takes priority: normal completion, no flag.
- Not defined: no counter; BUSY waits indefinitely; timeout_o tied 0.

Test Plan:
- m0 write adr=3 dat=0x5A, m1 idle → s_* mirrors m0 one cycle after request; m0_ack_o pulses once; s_dat_o[7:0]=0x5A.
- m0 and m1 both read continuously after reset → grants alternate m0,m1,m0,m1; each ack goes only to its owner; m1 read returns slave data 0x000000C3.
- m1 drops cyc one cycle into a read (Tube latency 3) → DRAIN; m0 request held until orphan s_ack_i; m1_ack_o never asserted; then m0 granted.
- s_ack_i pulsed while IDLE → no mX_ack_o; state stays IDLE.
- Reset asserted in BUSY → next cycle all slave outputs 0, state IDLE, last=1; then simultaneous requests grant m0.
- With TUBE_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks → owner ack at 4th BUSY cycle with data 0xFFFFFFFF; timeout_o=1 and stays 1; late s_ack_i consumed in DRAIN.
